prog_loader: RTL and testbench

- Boot-time program loader; sits directly upstream of the RV32i core's program memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into program memory, verifies a trailing XOR checksum, then releases the core from reset.
- Replaces direct memory preloading, so program images can be delivered through a synthesizable path.

---
 rtl/prog_loader.sv | 156 +++++++++++++++
 tb/tb_prog_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream, assembles
// little-endian 32-bit words, writes them into program memory, verifies a
// trailing XOR checksum and only then releases the core from reset.
module prog_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  core_rst_n_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   words_loaded_o
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    WORD,
    CSUM,
    DONE,
    ERR
  } state_e;

  // Largest legal word count: exactly fills the program memory.
  localparam logic [16:0] MAX_CNT = 17'(1) << ADDR_WIDTH;

  state_e                state_q;
  logic [15:0]           cnt_q;
  logic [1:0]            byteIdx_q;
  logic [ADDR_WIDTH:0]   wordIdx_q;
  logic [23:0]           shift_q;
  logic [7:0]            csum_q;
  logic                  inReady_q;
  logic                  memWe_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [31:0]           memWdata_q;
  logic                  coreRstN_q;
  logic                  done_q;
  logic                  err_q;

  logic                  accept_d;
  logic [16:0]           hdrCnt_d;
  logic [ADDR_WIDTH:0]   wordIdx_d;
  logic                  lastWord_d;

  // Handshake, full header count and word-index lookahead used by the FSM.
  assign accept_d   = in_valid_i & inReady_q;
  assign hdrCnt_d   = {1'b0, in_data_i, cnt_q[7:0]};
  assign wordIdx_d  = wordIdx_q + (ADDR_WIDTH+1)'(1);
  assign lastWord_d = (17'(wordIdx_d) == {1'b0, cnt_q});

  // Loader FSM with every output registered; done/err states are sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HDR0;
      cnt_q      <= '0;
      byteIdx_q  <= '0;
      wordIdx_q  <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      inReady_q  <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      coreRstN_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      memWe_q <= 1'b0;
      unique case (state_q)
        HDR0: begin
          inReady_q <= 1'b1;
          if (accept_d) begin
            cnt_q[7:0] <= in_data_i;
            csum_q     <= csum_q ^ in_data_i;
            state_q    <= HDR1;
          end
        end
        HDR1: begin
          if (accept_d) begin
            cnt_q[15:8] <= in_data_i;
            csum_q      <= csum_q ^ in_data_i;
            byteIdx_q   <= '0;
            wordIdx_q   <= '0;
            if (hdrCnt_d > MAX_CNT) begin
              state_q   <= ERR;
              err_q     <= 1'b1;
              inReady_q <= 1'b0;
            end else if (hdrCnt_d == 17'd0) begin
              state_q <= CSUM;
            end else begin
              state_q <= WORD;
            end
          end
        end
        WORD: begin
          if (accept_d) begin
            csum_q    <= csum_q ^ in_data_i;
            byteIdx_q <= byteIdx_q + 2'd1;
            if (byteIdx_q == 2'd3) begin
              memWe_q    <= 1'b1;
              memAddr_q  <= wordIdx_q[ADDR_WIDTH-1:0];
              memWdata_q <= {in_data_i, shift_q};
              wordIdx_q  <= wordIdx_d;
              if (lastWord_d) begin
                state_q <= CSUM;
              end
            end else begin
              shift_q <= {in_data_i, shift_q[23:8]};
            end
          end
        end
        CSUM: begin
          if (accept_d) begin
            inReady_q <= 1'b0;
            if (in_data_i == csum_q) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              coreRstN_q <= 1'b1;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          inReady_q <= 1'b0;
        end
        ERR: begin
          inReady_q <= 1'b0;
        end
        default: begin
          state_q   <= ERR;
          err_q     <= 1'b1;
          inReady_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o     = inReady_q;
  assign mem_we_o       = memWe_q;
  assign mem_addr_o     = memAddr_q;
  assign mem_wdata_o    = memWdata_q;
  assign core_rst_n_o   = coreRstN_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = wordIdx_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: frames are described as byte lists, a
// frame-level model derives the expected writes and outcome, and random
// frames with random in_valid gaps are mixed with fixed reference streams.
module tb_prog_loader;

  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst_n;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]     frame[$];
  logic [AW+31:0] gotQ[$];

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .core_rst_n_o   (core_rst_n),
    .done_o         (done),
    .err_o          (err),
    .words_loaded_o (words_loaded)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Capture every memory write pulse away from the active edge.
  always @(negedge clk) begin
    if (rst_n && mem_we) gotQ.push_back({mem_addr, mem_wdata});
  end

  // Hard time limit so the run can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ":in_ready"}, 64'(in_ready), 64'd0);
    checkOutput({tag, ":mem_we"}, 64'(mem_we), 64'd0);
    checkOutput({tag, ":mem_addr"}, 64'(mem_addr), 64'd0);
    checkOutput({tag, ":mem_wdata"}, 64'(mem_wdata), 64'd0);
    checkOutput({tag, ":core_rst_n"}, 64'(core_rst_n), 64'd0);
    checkOutput({tag, ":done"}, 64'(done), 64'd0);
    checkOutput({tag, ":err"}, 64'(err), 64'd0);
    checkOutput({tag, ":words"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkResetOutputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst:ready_after", 64'(in_ready), 64'd1);
    gotQ.delete();
  endtask

  // Offer one byte after a random idle gap; ok=1 once it has been accepted.
  task automatic applyStimulus(input logic [7:0] b, input int maxGap, output bit ok);
    int  gap;
    int  waited;
    bit  taken;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    taken    = 1'b0;
    waited   = 0;
    while (!taken && waited < 40) begin
      if (in_ready) begin
        @(posedge clk);
        taken = 1'b1;
      end
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b0;
    ok = taken;
  endtask

  // Build a frame with cnt random words and a correct or corrupted checksum.
  task automatic buildFrame(input int cnt, input bit goodCsum);
    logic [7:0] x;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(cnt));
    frame.push_back(8'(cnt >> 8));
    for (int i = 0; i < 4 * cnt; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
    end
    x = 8'h00;
    foreach (frame[i]) x = x ^ frame[i];
    if (!goodCsum) x = x ^ 8'($urandom_range(255, 1));
    frame.push_back(x);
  endtask

  // Frame-level model: expected writes, outcome and byte count come from the
  // frame contents alone; the bytes are then streamed and results compared.
  task automatic runFrame(input string name, input int maxGap);
    logic [AW+31:0] expQ[$];
    int             cnt;
    int             used;
    int             n;
    logic [7:0]     x;
    logic [31:0]    w;
    bit             expDone;
    bit             ok;
    bit             allOk;
    logic [AW+31:0] ge;

    cnt = int'(frame[0]) + 256 * int'(frame[1]);
    if (cnt > (1 << AW)) begin
      used    = 2;
      expDone = 1'b0;
      cnt     = 0;
    end else begin
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * cnt; i++) x = x ^ frame[i];
      for (int k = 0; k < cnt; k++) begin
        w = {frame[2+4*k+3], frame[2+4*k+2], frame[2+4*k+1], frame[2+4*k]};
        expQ.push_back({AW'(k), w});
      end
      used    = 2 + 4 * cnt + 1;
      expDone = (frame[used-1] == x);
    end

    gotQ.delete();
    allOk = 1'b1;
    for (int i = 0; i < used; i++) begin
      applyStimulus(frame[i], maxGap, ok);
      if (!ok) allOk = 1'b0;
    end
    checkOutput({name, ":accepted"}, 64'(allOk), 64'd1);

    checkOutput({name, ":done"}, 64'(done), 64'(expDone));
    checkOutput({name, ":err"}, 64'(err), 64'(!expDone));
    checkOutput({name, ":core_rst_n"}, 64'(core_rst_n), 64'(expDone));
    checkOutput({name, ":in_ready"}, 64'(in_ready), 64'd0);

    repeat (3) @(negedge clk);
    checkOutput({name, ":nwrites"}, 64'(gotQ.size()), 64'(expQ.size()));
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      ge = gotQ[i];
      checkOutput($sformatf("%s:addr%0d", name, i), 64'(ge[AW+31:32]), 64'(expQ[i][AW+31:32]));
      checkOutput($sformatf("%s:data%0d", name, i), 64'(ge[31:0]), 64'(expQ[i][31:0]));
    end
    if (expQ.size() > 0) begin
      checkOutput({name, ":hold"}, 64'({mem_addr, mem_wdata}), 64'(expQ[expQ.size()-1]));
    end
    checkOutput({name, ":words"}, 64'(words_loaded), 64'(cnt));
    checkOutput({name, ":sticky_done"}, 64'(done), 64'(expDone));
    checkOutput({name, ":exclusive"}, 64'(done & err), 64'd0);
  endtask

  task automatic loadBytes(input logic [7:0] b[]);
    frame.delete();
    foreach (b[i]) frame.push_back(b[i]);
  endtask

  initial begin
    logic [7:0] s1[];
    bit         ok;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    s1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
           8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};

    applyReset();
    loadBytes(s1);
    runFrame("s1", 0);

    applyReset();
    loadBytes(s1);
    frame[10] = 8'h74;
    runFrame("s1bad", 0);

    applyReset();
    loadBytes('{8'h00, 8'h00, 8'h00});
    runFrame("zero_ok", 0);

    applyReset();
    loadBytes('{8'h00, 8'h00, 8'h02});
    runFrame("zero_bad", 0);

    applyReset();
    loadBytes('{8'h01, 8'h01});
    runFrame("cnt257", 0);

    applyReset();
    loadBytes(s1);
    runFrame("s1gaps", 5);

    // Reset in the middle of a frame, then reload cleanly.
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(s1[i], 0, ok);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    loadBytes(s1);
    runFrame("reload", 0);

    for (int t = 0; t < 8; t++) begin
      applyReset();
      buildFrame(int'($urandom_range(6, 0)), ($urandom_range(3, 0) != 0));
      runFrame($sformatf("rand%0d", t), int'($urandom_range(3, 0)));
    end

    applyReset();
    buildFrame(1 << AW, 1'b1);
    runFrame("full", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
